// File: rtl/data_mem_pkg.sv
// Shared definitions for the MEM-stage data memory.
// FSM encoding, sign_mask bit map and size decode.
package data_mem_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_STORE_RD = 2'd2;
  localparam logic [1:0] ST_STORE_WR = 2'd3;

  localparam int SM_SIGNED = 3;
  localparam int SM_WORD   = 2;
  localparam int SM_HALF   = 1;
  localparam int SM_BYTE   = 0;

  localparam logic [31:0] DEF_LED_ADDR = 32'h0000_2000;

  // One-hot {word,half,byte}; word wins, and an empty mask means word
  function automatic logic [2:0] size_oh(input logic [2:0] m);
    if (m[SM_WORD] || (m == 3'b000))
      return 3'b100;
    else if (m[SM_HALF])
      return 3'b010;
    else
      return 3'b001;
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Lane extract/extend for loads and lane merge for stores.
// Purely combinational; size is one-hot {word,half,byte}.
module data_mem_align
  import data_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[{i_offset, 3'b000} +: 8];
    w_half   = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_load   = i_word;
    o_merged = i_wdata;
    unique case (1'b1)
      i_size[2]: begin
        o_load   = i_word;
        o_merged = i_wdata;
      end
      i_size[1]: begin
        o_load   = {{16{i_signed & w_half[15]}}, w_half};
        o_merged = i_word;
        o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      i_size[0]: begin
        o_load   = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged = i_word;
        o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_rmw.sv
// MEM-stage data memory: sized loads, RMW sub-word stores,
// one-cycle load stall, misalignment reject and an MMIO LED register.
module data_mem_rmw
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS   = 1024,
  parameter logic [31:0] MMIO_LED_ADDR = DEF_LED_ADDR,
  parameter int          LED_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           sign_mask,
  output logic [31:0]          read_data,
  output logic [LED_WIDTH-1:0] led,
  output logic                 clk_stall,
  output logic                 misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]           r_state;
  logic                 r_stall;
  logic                 r_mis;
  logic [31:0]          r_rdout;
  logic [LED_WIDTH-1:0] r_led;
  logic [AW-1:0]        r_idx;
  logic [1:0]           r_off;
  logic [31:0]          r_wdata;
  logic [3:0]           r_mask;
  logic                 r_is_led;
  logic [31:0]          r_mem [DEPTH_WORDS];
  logic [31:0]          r_ram_q;

  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_ridx;
  logic [2:0]    w_size_in;
  logic [2:0]    w_size_q;
  logic          w_mis;
  logic          w_led_hit;
  logic          w_req;
  logic [31:0]   w_led_word;
  logic [31:0]   w_word;
  logic [31:0]   w_load;
  logic [31:0]   w_merged;

  assign w_idx     = addr[AW+1:2];
  assign w_size_in = size_oh(sign_mask[2:0]);
  assign w_size_q  = size_oh(r_mask[2:0]);
  assign w_mis     = (w_size_in[1] & addr[0])
                   | (w_size_in[2] & (addr[1:0] != 2'b00));
  assign w_led_hit = (addr[31:2] == MMIO_LED_ADDR[31:2]);
  assign w_req     = memwrite | memread;
  // Address the RAM from the live bus in IDLE so the word is ready next cycle
  assign w_ridx    = (r_state == ST_IDLE) ? w_idx : r_idx;
  assign w_word    = r_is_led ? w_led_word : r_ram_q;

  always_comb begin
    w_led_word = '0;
    w_led_word[LED_WIDTH-1:0] = r_led;
  end

  data_mem_align u_align (
    .i_word   (w_word),
    .i_offset (r_off),
    .i_size   (w_size_q),
    .i_signed (r_mask[SM_SIGNED]),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (r_state == ST_STORE_WR)
      r_mem[r_idx] <= w_merged;
    r_ram_q <= r_mem[w_ridx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_stall  <= 1'b0;
      r_mis    <= 1'b0;
      r_rdout  <= '0;
      r_led    <= '0;
      r_idx    <= '0;
      r_off    <= '0;
      r_wdata  <= '0;
      r_mask   <= '0;
      r_is_led <= 1'b0;
    end else begin
      r_mis <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_idx    <= w_idx;
          r_off    <= addr[1:0];
          r_wdata  <= write_data;
          r_mask   <= sign_mask;
          r_is_led <= w_led_hit;
          if (w_req && w_mis) begin
            r_mis <= 1'b1;
          end else if (memwrite && w_led_hit) begin
            r_led <= write_data[LED_WIDTH-1:0];
          end else if (memwrite) begin
            r_state <= ST_STORE_RD;
            r_stall <= 1'b1;
          end else if (memread) begin
            r_state <= ST_LOAD;
            r_stall <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_rdout <= w_load;
          r_stall <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_STORE_RD: begin
          r_state <= ST_STORE_WR;
        end
        default: begin
          r_stall <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign read_data  = r_rdout;
  assign led        = r_led;
  assign clk_stall  = r_stall;
  assign misaligned = r_mis;

endmodule

// File: tb/tb_data_mem_rmw.sv
// Bench for data_mem_rmw: vector table with a load scoreboard,
// plus hand sequences for MMIO, misalignment and mid-store reset.
module tb_data_mem_rmw;

  localparam int          DEPTH = 256;
  localparam logic [31:0] LED_A = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [3:0]  sign_mask = '0;
  logic [31:0] read_data;
  logic [7:0]  led;
  logic        clk_stall;
  logic        misaligned;

  data_mem_rmw #(
    .DEPTH_WORDS   (DEPTH),
    .MMIO_LED_ADDR (LED_A),
    .LED_WIDTH     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .led        (led),
    .clk_stall  (clk_stall),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp;
    int          st;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] q_exp[$];
  logic [31:0] last_rd = '0;
  vec_t        v[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m,
                        output int stalls, output logic mis);
    @(negedge clk);
    addr = a; write_data = d; sign_mask = m;
    memwrite = wr; memread = rd;
    @(posedge clk);
    #1;
    memwrite = 1'b0; memread = 1'b0;
    mis = misaligned;
    stalls = 0;
    while (clk_stall && stalls < 8) begin
      stalls++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input string name, input logic [31:0] a,
                      input logic [3:0] m, input logic [31:0] exp);
    int st;
    logic mis;
    q_exp.push_back(exp);
    access(1'b0, 1'b1, a, 32'h0, m, st, mis);
    chk({name, " stalls"}, st, 1);
    if (q_exp.size() > 0) begin
      last_rd = q_exp.pop_front();
      chk(name, read_data, last_rd);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    int st;
    logic mis;
    access(1'b1, 1'b0, a, d, m, st, mis);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   st;
    logic mis;

    v.push_back('{1, 0, 32'h10,  32'hDEADBEEF, 4'b0100, 32'h0,        2});
    v.push_back('{0, 1, 32'h13,  32'h0,        4'b1001, 32'hFFFFFFDE, 1});
    v.push_back('{0, 1, 32'h12,  32'h0,        4'b0010, 32'h0000DEAD, 1});
    v.push_back('{0, 1, 32'h10,  32'h0,        4'b1010, 32'hFFFFBEEF, 1});
    v.push_back('{0, 1, 32'h10,  32'h0,        4'b0001, 32'h000000EF, 1});
    v.push_back('{0, 1, 32'h11,  32'h0,        4'b0001, 32'h000000BE, 1});
    v.push_back('{1, 0, 32'h10,  32'h11223344, 4'b0100, 32'h0,        2});
    v.push_back('{1, 0, 32'h11,  32'hFFFFFF5A, 4'b0001, 32'h0,        2});
    v.push_back('{0, 1, 32'h10,  32'h0,        4'b0100, 32'h11225A44, 1});
    v.push_back('{1, 0, 32'h12,  32'hAAAABEEF, 4'b0010, 32'h0,        2});
    v.push_back('{0, 1, 32'h10,  32'h0,        4'b0100, 32'hBEEF5A44, 1});
    v.push_back('{1, 0, 32'h10,  32'h00001234, 4'b0010, 32'h0,        2});
    v.push_back('{0, 1, 32'h10,  32'h0,        4'b1100, 32'hBEEF1234, 1});
    v.push_back('{1, 0, 32'h00,  32'h12345678, 4'b0100, 32'h0,        2});
    v.push_back('{0, 1, 32'h10,  32'h0,        4'b0000, 32'hBEEF1234, 1});
    v.push_back('{1, 0, 32'h404, 32'hCAFEF00D, 4'b0100, 32'h0,        2});
    v.push_back('{0, 1, 32'h04,  32'h0,        4'b0100, 32'hCAFEF00D, 1});
    v.push_back('{0, 1, 32'h407, 32'h0,        4'b1001, 32'hFFFFFFCA, 1});
    v.push_back('{1, 1, 32'h08,  32'h0BADF00D, 4'b0100, 32'h0,        2});
    v.push_back('{0, 1, 32'h08,  32'h0,        4'b0100, 32'h0BADF00D, 1});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset read_data", read_data, 32'h0);
    chk("reset led", {24'h0, led}, 32'h0);
    chk("reset stall", {31'h0, clk_stall}, 32'h0);
    chk("reset misaligned", {31'h0, misaligned}, 32'h0);

    foreach (v[i]) begin
      if (!v[i].wr) q_exp.push_back(v[i].exp);
      access(v[i].wr, v[i].rd, v[i].a, v[i].d, v[i].m, st, mis);
      chk($sformatf("v%0d stalls", i), st, v[i].st);
      chk($sformatf("v%0d misaligned", i), {31'h0, mis}, 32'h0);
      if (v[i].wr) begin
        chk($sformatf("v%0d read_data hold", i), read_data, last_rd);
      end else if (q_exp.size() > 0) begin
        last_rd = q_exp.pop_front();
        chk($sformatf("v%0d load", i), read_data, last_rd);
      end
    end

    access(1'b1, 1'b0, LED_A, 32'hFFFFFFA5, 4'b0100, st, mis);
    chk("led store value", {24'h0, led}, 32'h000000A5);
    chk("led store stalls", st, 0);
    chk("led store read_data hold", read_data, last_rd);
    load("led store ram untouched", 32'h0, 4'b0100, 32'h12345678);
    load("led word load", LED_A, 4'b0100, 32'h000000A5);
    load("led signed byte load", LED_A, 4'b1001, 32'hFFFFFFA5);

    store(32'h20, 32'h55667788, 4'b0100);
    access(1'b1, 1'b0, 32'h21, 32'h0000FFFF, 4'b0010, st, mis);
    chk("mis half store pulse", {31'h0, mis}, 32'h1);
    chk("mis half store stalls", st, 0);
    @(posedge clk);
    #1;
    chk("mis pulse one cycle", {31'h0, misaligned}, 32'h0);
    load("mis store ram untouched", 32'h20, 4'b0100, 32'h55667788);
    access(1'b0, 1'b1, 32'h22, 32'h0, 4'b0100, st, mis);
    chk("mis word load pulse", {31'h0, mis}, 32'h1);
    chk("mis word load stalls", st, 0);
    chk("mis word load hold", read_data, last_rd);

    store(32'h30, 32'h01020304, 4'b0100);
    @(negedge clk);
    addr = 32'h30; write_data = 32'h0000FFFF;
    sign_mask = 4'b0010; memwrite = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    chk("rst seq stall store_rd", {31'h0, clk_stall}, 32'h1);
    @(posedge clk);
    #1;
    chk("rst seq stall store_wr", {31'h0, clk_stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst seq stall cleared", {31'h0, clk_stall}, 32'h0);
    chk("rst seq read_data", read_data, 32'h0);
    chk("rst seq led", {24'h0, led}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    load("rst seq word unchanged", 32'h30, 4'b0100, 32'h01020304);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
